// File: rtl/mac_job_arbiter.sv
// Round-robin arbiter sharing one sample_controller (BRAM + MAC) between N requesters.
// Runs each latched job through the r_valid/read_done/t_valid handshake and routes the result back.
module mac_job_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDLE_GAP = 4,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [32*N-1:0]   req_data,
  output logic [N-1:0]      ack,
  output logic [N-1:0]      done,
  output logic [7:0]        res_data,
  output logic              res_err,
  output logic              busy,
  output logic              r_valid,
  output logic [31:0]       in_data,
  input  logic              read_done,
  input  logic              t_valid,
  input  logic [7:0]        out_data
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(IDLE_GAP + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_T, RESP, GAP} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;

  logic [31:0]   jobs [N];
  logic [IW-1:0] grant_c;
  logic [IW-1:0] idx_c;
  logic          grant_vld_c;
  logic          tmo_c;

  for (genvar i = 0; i < N; i++) begin : g_job
    assign jobs[i] = req_data[32*i +: 32];
  end

  // First requesting index searching upward from last+1 with wrap
  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = '0;
    idx_c       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx_c = IW'((32'(last) + i) % N);
      if (!grant_vld_c && req[idx_c]) begin
        grant_vld_c = 1'b1;
        grant_c     = idx_c;
      end
    end
  end

  assign tmo_c = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IW'(N - 1);
      tcnt     <= '0;
      gcnt     <= '0;
      ack      <= '0;
      done     <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
      busy     <= 1'b0;
      r_valid  <= 1'b0;
      in_data  <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (grant_vld_c) begin
            in_data       <= jobs[grant_c];
            last          <= grant_c;
            ack[grant_c]  <= 1'b1;
            tcnt          <= '0;
            r_valid       <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (read_done) begin
            r_valid <= 1'b0;
            tcnt    <= '0;
            state   <= WAIT_T;
          end else if (tmo_c) begin
            r_valid    <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b1;
            done[last] <= 1'b1;
            state      <= RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_T: begin
          if (t_valid) begin
            res_data   <= out_data;
            res_err    <= 1'b0;
            done[last] <= 1'b1;
            state      <= RESP;
          end else if (tmo_c) begin
            res_data   <= '0;
            res_err    <= 1'b1;
            done[last] <= 1'b1;
            state      <= RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RESP: begin
          gcnt    <= GW'(IDLE_GAP - 1);
          in_data <= '0;
          state   <= GAP;
        end
        GAP: begin
          // Quiet window so the controller can settle back to idle
          if (gcnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gcnt <= gcnt - GW'(1);
          end
        end
        default: begin
          r_valid <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
